pattern_checker: RTL
====================

Name: pattern_checker

Overview:
- Receive-side companion to the pipe-pattern generator.
- Samples the generator's WIDTH-bit state on each step strobe and predicts the next value using the generator's own update rule.
- Declares lock after a run of correct steps, flags mismatches and counts errors, and detects the all-ones lockup state.
- Sits between the pattern generator and the pipe/obstacle logic, so the game can gate pipe spawning on a healthy pattern stream.

Parameters:
- WIDTH, 3, pattern width in bits (>=2); must equal the generator's width.
- LOCK_COUNT, 4, consecutive correct steps required to assert locked (1..15).
- UNLOCK_COUNT, 2, consecutive mismatches while locked that drop lock (1..15).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- pat_valid  input  1  one-cycle strobe; pat_in is a new generator state this cycle.
- pat_in  input  WIDTH  sampled generator state.
- locked  output  1  high while the checker is in LOCKED.
- mismatch  output  1  one-cycle pulse on a failed prediction while LOCKED.
- lockup  output  1  sticky; set when pat_in is all ones on a valid sample.
- err_count  output  ERRW  saturating count of LOCKED mismatches.
- expected  output  WIDTH  prediction for the next valid sample.

Behaviour:
- Next-state function: f(q) = {q[WIDTH-2:0], ~(q[WIDTH-1] ^ q[WIDTH-2])}.
- For WIDTH=3 the cycle is 000→001→011→110→101→010→100→000, period 7; 111 maps to itself (lockup).
- Internal registers:
  - prev (WIDTH), have_prev (1), match_cnt and miss_cnt (4 bits each).
  - State: SEARCH or LOCKED.
- Reset: state=SEARCH, have_prev=0, counters=0, prev=0. All outputs 0: locked=0, mismatch=0, lockup=0, err_count=0, expected=0.
- Cycles with pat_valid=0: all state holds; mismatch=0.
- On pat_valid=1:
  - prev<=pat_in and have_prev<=1 on every valid sample.
  - expected<=f(pat_in); registered, so visible the cycle after the sample.
  - If pat_in is all ones: lockup<=1 (sticky until reset) and the sample is treated as a mismatch.
  - have_prev=0: load only; no compare, no counter change.
  - Match means have_prev=1, pat_in==f(prev), and pat_in is not all ones.
- SEARCH:
  - Match: match_cnt++. When match_cnt+1==LOCK_COUNT, go to LOCKED with locked<=1, match_cnt<=0, miss_cnt<=0.
  - Mismatch: match_cnt<=0; stay in SEARCH; no mismatch pulse, no err_count change (resync only).
- LOCKED:
  - Match: miss_cnt<=0.
  - Mismatch: mismatch<=1 for exactly one cycle, err_count++ saturating at 2^ERRW-1, miss_cnt++.
  - When miss_cnt+1==UNLOCK_COUNT, go to SEARCH with locked<=0, miss_cnt<=0, match_cnt<=0.
- Latency: locked, mismatch, err_count and expected all update on the clock edge that samples pat_valid (1-cycle registered).
- Reset mid-operation: reset wins over pat_valid in the same cycle; everything returns to reset values, including lockup and err_count.
- Back-to-back pat_valid on every cycle must be supported with no lost samples.

Test Plan:
- Reset, then valid samples 000,001,011,110,101 on consecutive cycles → locked=0 through the 4th sample; locked=1 after the 5th sample's edge; mismatch never asserted; expected=010 after the last sample.
- While locked, feed 010,100,000,001 then 111 → lockup=1, mismatch pulses once, err_count=1, locked stays 1 (UNLOCK_COUNT=2).
- While locked, feed two wrong values (e.g. after 001, feed 110 then 000) → two mismatch pulses, err_count+=2, locked=0 after the second; the next 4 correct steps relock.
- In SEARCH, feed 000,001,011,101 → match_cnt resets at 101, no mismatch pulse, err_count unchanged; then 010,100,000,001 → locked=1.
- With ERRW=2, force 5 mismatches while locked (relocking between pairs) → err_count saturates at 3.
- Assert reset for one cycle coincident with pat_valid while locked with err_count=2 and lockup=1 → next cycle all outputs 0 and state=SEARCH; the first valid sample after reset only loads.

Source files
------------

// File: rtl/pattern_checker.sv
// pattern_checker: receive-side checker for the pipe-pattern generator.
// Every time pat_valid strobes, the checker predicts the next generator state
// from the previous sample. It declares lock after LOCK_COUNT correct steps in
// a row. While locked, it pulses mismatch and counts errors. It also records
// the all-ones lockup state, which the generator cannot leave on its own.
//
// Handshake: pat_valid is a one-cycle strobe with no backpressure. Each cycle
// in which pat_valid is high carries one new sample on pat_in. Samples may
// arrive on every cycle. All outputs are registered and change on the edge
// that consumes the sample.
module pattern_checker #(
    parameter int WIDTH        = 3,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2,
    parameter int ERRW         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pat_valid,
    input  logic [WIDTH-1:0] pat_in,
    output logic             locked,
    output logic             mismatch,
    output logic             lockup,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] expected,
    output logic             dbg_state
);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Counters hold (count - 1) at the moment the threshold is reached.
    localparam logic [3:0]      LOCK_LAST   = 4'(LOCK_COUNT - 1);
    localparam logic [3:0]      UNLOCK_LAST = 4'(UNLOCK_COUNT - 1);
    localparam logic [ERRW-1:0] ERR_MAX     = '1;

    // Generator update rule: shift left, feed back XNOR of the top two bits.
    function automatic logic [WIDTH-1:0] next_pat(input logic [WIDTH-1:0] q);
        return {q[WIDTH-2:0], ~(q[WIDTH-1] ^ q[WIDTH-2])};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             lockup_q, lockup_d;
    logic [ERRW-1:0]  err_count_q, err_count_d;
    logic [WIDTH-1:0] expected_q, expected_d;

    logic all_ones;
    logic pred_hit;

    // Next-state and registered-output computation for one sample.
    always_comb begin
        all_ones    = &pat_in;
        // An all-ones sample is never a good step, even if it is predicted.
        pred_hit    = have_prev_q && (pat_in == next_pat(prev_q)) && !all_ones;

        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        mismatch_d  = 1'b0;
        lockup_d    = lockup_q;
        err_count_d = err_count_q;
        expected_d  = expected_q;

        if (pat_valid) begin
            prev_d      = pat_in;
            have_prev_d = 1'b1;
            expected_d  = next_pat(pat_in);
            if (all_ones) begin
                lockup_d = 1'b1;
            end

            // With no previous sample there is nothing to compare against.
            // The first sample is only loaded.
            if (have_prev_q) begin
                case (state_q)
                    ST_SEARCH: begin
                        if (pred_hit) begin
                            if (match_cnt_q == LOCK_LAST) begin
                                state_d     = ST_LOCKED;
                                locked_d    = 1'b1;
                                match_cnt_d = 4'd0;
                                miss_cnt_d  = 4'd0;
                            end else begin
                                match_cnt_d = match_cnt_q + 4'd1;
                            end
                        end else begin
                            // Resynchronise quietly; errors only count once locked.
                            match_cnt_d = 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (pred_hit) begin
                            miss_cnt_d = 4'd0;
                        end else begin
                            mismatch_d = 1'b1;
                            if (err_count_q != ERR_MAX) begin
                                err_count_d = err_count_q + ERRW'(1);
                            end
                            if (miss_cnt_q == UNLOCK_LAST) begin
                                state_d     = ST_SEARCH;
                                locked_d    = 1'b0;
                                miss_cnt_d  = 4'd0;
                                match_cnt_d = 4'd0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_SEARCH;
                    end
                endcase
            end
        end
    end

    // State and output registers. Reset takes priority over any sample in
    // the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            lockup_q    <= 1'b0;
            err_count_q <= '0;
            expected_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            mismatch_q  <= mismatch_d;
            lockup_q    <= lockup_d;
            err_count_q <= err_count_d;
            expected_q  <= expected_d;
        end
    end

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign lockup    = lockup_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
    assign dbg_state = state_q;

endmodule
